nn_param_loader: RTL and testbench
==================================

# nn_param_loader

Parametrised serial loader for neural-network layer parameters: per-neuron weights, bias and threshold, for NEURONS neurons of INPUTS inputs, each WIDTH bits. Words stream in through a valid/ready handshake and shift through one register chain; the full parameter set is presented as a flat bus to the neuron datapath. Adds what the fixed-size loader lacks: load counting, completion flag, write blocking once full, circular readback and synchronous clear.

## Interface
- WIDTH, 8, bits per parameter word
- NEURONS, 4, neurons in the layer
- INPUTS, 4, weights per neuron
- Derived: WPN = INPUTS+2 words per neuron; DEPTH = NEURONS*WPN (must be ≥2); CW = $clog2(DEPTH+1); RW = $clog2(DEPTH)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- mode  in  2  00 hold, 01 load, 10 rotate (readback), 11 clear
- in_valid  in  1  in_data holds a word
- in_data  in  WIDTH  parameter word
- in_ready  out  1  loader accepts a word this cycle
- params_flat  out  DEPTH*WIDTH  word k at bits [k*WIDTH +: WIDTH]
- out_data  out  WIDTH  word 0 (readback head)
- load_count  out  CW  words accepted since reset/clear
- load_done  out  1  load_count == DEPTH
- rot_idx  out  RW  original index of word currently at position 0

## Operation
- Word map: k = n*WPN + j; j<INPUTS is weight w[n][j]; j=INPUTS is bias b[n]; j=INPUTS+1 is threshold th[n].
- Load order: first word sent is word 0 (w[0][0]), last is word DEPTH-1 (th[NEURONS-1]).
- Accept = in_valid & in_ready; in_ready = (mode==01) & ~load_done (combinational).
- On accept: word[k] <= word[k+1] for k<DEPTH-1; word[DEPTH-1] <= in_data; load_count += 1. After DEPTH accepts the map above holds exactly.
- No accept (mode 01, in_valid low): everything holds.
- mode 00: everything holds; load_count retained; a later return to 01 resumes the load.
- mode 10 with load_done=1: rotate down one word per cycle: word[k] <= word[k+1], word[DEPTH-1] <= word[0]. rot_idx += 1, wrapping DEPTH-1 -> 0. load_count is unchanged.
- mode 10 with load_done=0: behaves as hold.
- mode 11: all words <= 0, load_count <= 0, rot_idx <= 0. in_valid is ignored.
- Writes after load_done are refused (in_ready=0) until clear or reset. The chain never shifts on a refused word.
- out_data = word[0], combinational from the register.
- load_done = (load_count == DEPTH), combinational from the counter.

## Timing
- Reset values: all words 0, params_flat 0, out_data 0, load_count 0, load_done 0, rot_idx 0. in_ready follows mode after reset.
- Reset dominates mode and in_valid. Reset mid-load discards the partial load in one cycle.
- Accept latency: a word accepted on edge t appears at word[DEPTH-1] after t. load_count updates on the same edge.
- load_done rises in the cycle after the DEPTH-th accept. in_ready falls in the same cycle.
- Full throughput: one word per cycle with in_valid held; a full load takes DEPTH cycles.
- Rotation: after r rotate cycles, word[0] = original word (r mod DEPTH). DEPTH rotations restore the original map with rot_idx=0.
- Mode is sampled every cycle; switching modes needs no idle gap.

## Test plan (WIDTH=8, NEURONS=4, INPUTS=4, DEPTH=24)
- Reset, then mode=01 -> all outputs 0, load_count 0, in_ready 1. With mode=00, in_ready is 0.
- Stream 0x01..0x18 back-to-back -> load_done after the 24th word; word0=0x01 (w00), word4=0x05 (b0), word5=0x06 (th0), word23=0x18 (th3). A 25th word 0x99 is refused (in_ready 0) and the map is unchanged.
- Load 10 words, then 5 cycles of mode=00 and 3 cycles of mode=01 with in_valid=0, then the remaining 14 -> load_count holds at 10 during the gap; the final map is identical to the previous test.
- After a full load, mode=10 for 3 cycles -> out_data=0x04, rot_idx=3. Continue to 24 total cycles -> out_data=0x01, rot_idx=0, map restored. mode=10 before load_done -> no change.
- After a full load, mode=11 for one cycle -> all words 0, load_count 0, load_done 0, in_ready 1 under mode=01.
- Accept 7 words, then assert reset for 1 cycle with in_valid high -> all zero next cycle, nothing accepted; a subsequent full load completes correctly.

Source files
------------

// File: rtl/nn_param_loader.sv
// nn_param_loader: serial loader for one neural-network layer's parameters.
// Words stream in one per accepted handshake and shift down a single register
// chain. Word k = n*WPN + j holds w[n][j] for j<INPUTS, b[n] for j=INPUTS and
// th[n] for j=INPUTS+1. The whole set is exposed as a flat bus to the neuron
// datapath. Once loaded, the chain can be rotated for circular readback
// through out_data, and cleared synchronously.
module nn_param_loader #(
   parameter int WIDTH   = 8,
   parameter int NEURONS = 4,
   parameter int INPUTS  = 4,
   localparam int WPN    = INPUTS + 2,
   localparam int DEPTH  = NEURONS * WPN,
   localparam int CW     = $clog2(DEPTH + 1),
   localparam int RW     = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               mode,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   output logic [DEPTH*WIDTH-1:0]   params_flat,
   output logic [WIDTH-1:0]         out_data,
   output logic [CW-1:0]            load_count,
   output logic                     load_done,
   output logic [RW-1:0]            rot_idx
);

   // Operating mode, sampled every cycle; no idle gap is needed between modes.
   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_LOAD   = 2'b01,
      MODE_ROTATE = 2'b10,
      MODE_CLEAR  = 2'b11
   } mode_e;

   // Parameter chain, load counter and rotation index.
   logic [WIDTH-1:0] r_words [DEPTH];
   logic [CW-1:0]    r_load_count;
   logic [RW-1:0]    r_rot_idx;

   logic             w_load_done;
   logic             w_ready;
   logic             w_accept;
   logic             w_rotate;
   logic             w_clear;
   mode_e            w_mode;

   // Handshake: a word transfers on a rising edge exactly when in_valid and
   // in_ready are both high in the cycle before it. in_ready depends only on
   // mode and the completion flag, never on in_valid, so the producer may
   // hold in_valid and data steady until it sees in_ready. A refused word
   // leaves the chain and counter untouched.
   assign w_mode      = mode_e'(mode);
   assign w_load_done = (r_load_count == CW'(DEPTH));
   assign w_ready     = (w_mode == MODE_LOAD) && !w_load_done;
   assign w_accept    = in_valid && w_ready;
   assign w_rotate    = (w_mode == MODE_ROTATE) && w_load_done;
   assign w_clear     = (w_mode == MODE_CLEAR);

   // Shift chain: load shifts new words in at the tail, rotate recirculates the head.
   always_ff @(posedge clk) begin
      if (reset || w_clear) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_words[k] <= '0;
         end
      end else if (w_accept) begin
         for (int k = 0; k < DEPTH - 1; k++) begin
            r_words[k] <= r_words[k+1];
         end
         r_words[DEPTH-1] <= in_data;
      end else if (w_rotate) begin
         for (int k = 0; k < DEPTH - 1; k++) begin
            r_words[k] <= r_words[k+1];
         end
         r_words[DEPTH-1] <= r_words[0];
      end
   end

   // Count accepted words; saturates naturally because in_ready drops at DEPTH.
   always_ff @(posedge clk) begin
      if (reset || w_clear) begin
         r_load_count <= '0;
      end else if (w_accept) begin
         r_load_count <= r_load_count + CW'(1);
      end
   end

   // Track which original word sits at the head while rotating, wrapping at DEPTH.
   always_ff @(posedge clk) begin
      if (reset || w_clear) begin
         r_rot_idx <= '0;
      end else if (w_rotate) begin
         if (r_rot_idx == RW'(DEPTH - 1)) begin
            r_rot_idx <= '0;
         end else begin
            r_rot_idx <= r_rot_idx + RW'(1);
         end
      end
   end

   // Flatten the chain: word k occupies bits [k*WIDTH +: WIDTH].
   always_comb begin
      params_flat = '0;
      for (int k = 0; k < DEPTH; k++) begin
         params_flat[k*WIDTH +: WIDTH] = r_words[k];
      end
   end

   assign in_ready   = w_ready;
   assign out_data   = r_words[0];
   assign load_count = r_load_count;
   assign load_done  = w_load_done;
   assign rot_idx    = r_rot_idx;

endmodule

// File: tb/tb_nn_param_loader.sv
// Bench for nn_param_loader with WIDTH=8, NEURONS=4, INPUTS=4 (DEPTH=24).
module tb_nn_param_loader;

   localparam int W     = 8;
   localparam int DEPTH = 24;
   localparam int CW    = 5;
   localparam int RW    = 5;

   // clock / reset
   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [1:0]        mode = 2'b01;
   logic              in_valid = 1'b0;
   logic [W-1:0]      in_data = '0;
   logic              in_ready;
   logic [DEPTH*W-1:0] params_flat;
   logic [W-1:0]      out_data;
   logic [CW-1:0]     load_count;
   logic              load_done;
   logic [RW-1:0]     rot_idx;

   always #5 clk = ~clk;

   nn_param_loader #(.WIDTH(8), .NEURONS(4), .INPUTS(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .mode        (mode),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .params_flat (params_flat),
      .out_data    (out_data),
      .load_count  (load_count),
      .load_done   (load_done),
      .rot_idx     (rot_idx)
   );

   // scoreboard
   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [1:0]    mode;
      logic          valid;
      logic [W-1:0]  data;
      logic          exp_ready;   // in_ready before the edge
      logic [W-1:0]  exp_out;     // out_data after the edge
      logic [CW-1:0] exp_cnt;
      logic          exp_done;
      logic [RW-1:0] exp_rot;
   } vec_t;

   vec_t vecs[28];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // driver: apply inputs from a negedge and advance one full cycle
   task automatic cycle(input logic [1:0] m, input logic v, input logic [W-1:0] d);
      mode = m;
      in_valid = v;
      in_data = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   // stream values first..last back-to-back in load mode
   task automatic load_range(input int first, input int last);
      for (int v = first; v <= last; v++) begin
         cycle(2'b01, 1'b1, W'(v));
      end
   endtask

   // expected map: word k holds value ((k + r) mod DEPTH) + 1
   task automatic push_map(input int r);
      for (int k = 0; k < DEPTH; k++) begin
         exp_q.push_back(W'(((k + r) % DEPTH) + 1));
      end
   endtask

   task automatic push_zero_map();
      for (int k = 0; k < DEPTH; k++) begin
         exp_q.push_back('0);
      end
   endtask

   task automatic check_map(input string name);
      logic [W-1:0] e;
      for (int k = 0; k < DEPTH; k++) begin
         e = exp_q.pop_front();
         check($sformatf("%s word%0d", name, k), 32'(params_flat[k*W +: W]), 32'(e));
      end
   endtask

   task automatic check_state(input string name, input logic [W-1:0] o, input logic [CW-1:0] c,
                              input logic d, input logic [RW-1:0] r);
      check({name, " out_data"},   32'(out_data),   32'(o));
      check({name, " load_count"}, 32'(load_count), 32'(c));
      check({name, " load_done"},  32'(load_done),  32'(d));
      check({name, " rot_idx"},    32'(rot_idx),    32'(r));
   endtask

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // table: full load 0x01..0x18, refused 25th word, three rotations
      for (int i = 0; i < DEPTH; i++) begin
         vecs[i] = '{2'b01, 1'b1, W'(i + 1), 1'b1,
                     (i == DEPTH - 1) ? 8'h01 : 8'h00,
                     CW'(i + 1), (i == DEPTH - 1), '0};
      end
      vecs[24] = '{2'b01, 1'b1, 8'h99, 1'b0, 8'h01, 5'd24, 1'b1, 5'd0};
      vecs[25] = '{2'b10, 1'b0, 8'h00, 1'b0, 8'h02, 5'd24, 1'b1, 5'd1};
      vecs[26] = '{2'b10, 1'b1, 8'h55, 1'b0, 8'h03, 5'd24, 1'b1, 5'd2};
      vecs[27] = '{2'b10, 1'b0, 8'h00, 1'b0, 8'h04, 5'd24, 1'b1, 5'd3};

      // reset
      reset = 1'b1;
      mode = 2'b01;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset in_ready mode01", 32'(in_ready), 32'd1);
      check_state("reset", 8'h00, 5'd0, 1'b0, 5'd0);
      push_zero_map();
      check_map("reset map");
      mode = 2'b00;
      #1;
      check("in_ready mode00", 32'(in_ready), 32'd0);
      @(negedge clk);

      // table-driven vectors
      for (int i = 0; i < 28; i++) begin
         mode = vecs[i].mode;
         in_valid = vecs[i].valid;
         in_data = vecs[i].data;
         #1;
         check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
         @(posedge clk);
         @(negedge clk);
         check_state($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_cnt,
                     vecs[i].exp_done, vecs[i].exp_rot);
      end
      // the refused 0x99 must not appear; the map is the loaded one rotated by 3
      push_map(3);
      check_map("rot3 map");

      // continue rotating to 24 total: map restored, rot_idx wraps to 0
      for (int i = 0; i < 21; i++) begin
         cycle(2'b10, 1'b0, '0);
      end
      check_state("rot24", 8'h01, 5'd24, 1'b1, 5'd0);
      push_map(0);
      check_map("rot24 map");
      check("loaded word4 bias0", 32'(params_flat[4*W +: W]), 32'h05);
      check("loaded word5 th0",   32'(params_flat[5*W +: W]), 32'h06);
      check("loaded word23 th3",  32'(params_flat[23*W +: W]), 32'h18);

      // clear for one cycle
      cycle(2'b11, 1'b1, 8'hAA);
      check_state("clear", 8'h00, 5'd0, 1'b0, 5'd0);
      push_zero_map();
      check_map("clear map");
      mode = 2'b01;
      in_valid = 1'b0;
      #1;
      check("clear in_ready mode01", 32'(in_ready), 32'd1);
      @(negedge clk);

      // rotate before load_done behaves as hold
      load_range(1, 3);
      cycle(2'b10, 1'b0, '0);
      cycle(2'b10, 1'b1, 8'h42);
      check_state("rot partial", 8'h00, 5'd3, 1'b0, 5'd0);
      check("rot partial word23", 32'(params_flat[23*W +: W]), 32'h03);
      check("rot partial word21", 32'(params_flat[21*W +: W]), 32'h01);
      cycle(2'b11, 1'b0, '0);

      // load with a hold gap and an idle load gap
      load_range(1, 10);
      for (int i = 0; i < 5; i++) begin
         mode = 2'b00;
         in_valid = 1'b1;
         in_data = 8'hEE;
         #1;
         check($sformatf("gap hold%0d in_ready", i), 32'(in_ready), 32'd0);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("gap hold%0d load_count", i), 32'(load_count), 32'd10);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(2'b01, 1'b0, 8'hEE);
         check($sformatf("gap idle%0d load_count", i), 32'(load_count), 32'd10);
      end
      load_range(11, 24);
      check_state("gap load", 8'h01, 5'd24, 1'b1, 5'd0);
      push_map(0);
      check_map("gap map");

      // reset mid-load with in_valid high
      cycle(2'b11, 1'b0, '0);
      load_range(1, 7);
      check("pre-reset load_count", 32'(load_count), 32'd7);
      reset = 1'b1;
      cycle(2'b01, 1'b1, 8'h77);
      reset = 1'b0;
      check_state("midload reset", 8'h00, 5'd0, 1'b0, 5'd0);
      push_zero_map();
      check_map("midload reset map");
      load_range(1, 24);
      in_valid = 1'b0;
      check_state("reload", 8'h01, 5'd24, 1'b1, 5'd0);
      push_map(0);
      check_map("reload map");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
